// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S serializer blocks: default widths,
// serializer state encoding and frame-length helpers.
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 16;
    localparam int I2S_PSCR_WIDTH = 16;
    localparam int FRAME_BITS     = 2 * I2S_DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_tx_state_e;

    // One frame carries a left and a right word back to back.
    function automatic int frame_len(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides the audio clock by 2*(pscr_i+1) while run_i is
// high and flags the cycles on which sck is about to rise or fall.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int PSCR_WIDTH = I2S_PSCR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  run_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    output logic                  sck_o,
    output logic                  fall_evt_o,
    output logic                  rise_evt_o
);

    logic [PSCR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  sck_q, sck_d;
    logic                  terminal;

    // Terminal count: sck toggles at the end of this cycle.
    assign terminal = run_i && (cnt_q == pscr_i);

    // Next-state logic for the prescaler count and the bit clock.
    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!run_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (terminal) begin
            cnt_d = '0;
            sck_d = ~sck_q;
        end else begin
            cnt_d = cnt_q + PSCR_WIDTH'(1);
        end
    end

    // Prescaler and bit-clock registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o      = sck_q;
    assign fall_evt_o = terminal && sck_q;
    assign rise_evt_o = terminal && !sck_q;

endmodule

// File: rtl/i2s_tx_ser.sv
// I2S transmit serializer: holds one stereo sample pair, shifts it out
// MSB first in Philips format (data one bit behind ws) and flags underflow.
module i2s_tx_ser
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int PSCR_WIDTH = I2S_PSCR_WIDTH
) (
    input  logic                  aud_clk_i,
    input  logic                  aud_rst_n_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    input  logic                  smpl_valid_i,
    output logic                  smpl_ready_o,
    input  logic [DATA_WIDTH-1:0] smpl_l_i,
    input  logic [DATA_WIDTH-1:0] smpl_r_i,
    output logic                  sck_o,
    output logic                  ws_o,
    output logic                  sd_o,
    output logic                  busy_o,
    output logic                  udf_o
);

    localparam int               FRAME_LEN = frame_len(DATA_WIDTH);
    localparam int               IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] IDX_HALF  = IDX_W'(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);

    i2s_tx_state_e          state_q, state_d;
    logic                   start_q, start_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [FRAME_LEN-1:0]   shift_q, shift_d;
    logic                   dly_q, dly_d;
    logic                   ws_q, ws_d;
    logic                   sd_q, sd_d;
    logic                   udf_q, udf_d;
    logic                   hold_vld_q, hold_vld_d;
    logic [FRAME_LEN-1:0]   hold_q, hold_d;

    logic                   run_en;
    logic                   sck_w;
    logic                   fall_evt;
    logic                   rise_evt_unused;
    logic                   bit_evt;
    logic                   take_hold;
    logic                   take_bypass;
    logic [FRAME_LEN-1:0]   word;

    // Dropping en_i stops the bit clock on the very next edge.
    assign run_en = (state_q == RUN) && en_i;

    i2s_clkgen #(
        .PSCR_WIDTH (PSCR_WIDTH)
    ) u_clkgen (
        .clk_i      (aud_clk_i),
        .rst_n_i    (aud_rst_n_i),
        .run_i      (run_en),
        .pscr_i     (pscr_i),
        .sck_o      (sck_w),
        .fall_evt_o (fall_evt),
        .rise_evt_o (rise_evt_unused)
    );

    // Bits advance on each sck falling edge; the first RUN cycle opens bit 0.
    assign bit_evt = run_en && (start_q || fall_evt);

    // FSM and serializer datapath: load at bit 0, shift through the delay bit.
    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        dly_d       = dly_q;
        ws_d        = ws_q;
        sd_d        = sd_q;
        udf_d       = 1'b0;
        take_hold   = 1'b0;
        take_bypass = 1'b0;
        word        = shift_q;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end
            end
            RUN: begin
                if (!en_i) begin
                    // Abandon the frame; the holding register is kept.
                    state_d   = IDLE;
                    bit_idx_d = '0;
                    shift_d   = '0;
                    dly_d     = 1'b0;
                    ws_d      = 1'b0;
                    sd_d      = 1'b0;
                end else if (bit_evt) begin
                    if (bit_idx_q == '0) begin
                        if (hold_vld_q) begin
                            word      = hold_q;
                            take_hold = 1'b1;
                        end else if (smpl_valid_i && !clr_i) begin
                            word        = {smpl_l_i, smpl_r_i};
                            take_bypass = 1'b1;
                        end else begin
                            word  = '0;
                            udf_d = 1'b1;
                        end
                    end
                    // The MSB of the word goes into the delay bit, so sd_o
                    // trails ws_o by exactly one bit period.
                    ws_d      = (bit_idx_q >= IDX_HALF);
                    sd_d      = dly_q;
                    dly_d     = word[FRAME_LEN-1];
                    shift_d   = {word[FRAME_LEN-2:0], 1'b0};
                    bit_idx_d = (bit_idx_q == IDX_LAST) ? '0 : bit_idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register. Handshake: a sample transfers on a cycle where
    // smpl_valid_i and smpl_ready_o are both high; smpl_ready_o is simply
    // "holding register empty" and does not depend on smpl_valid_i. A transfer
    // that meets an empty register at a frame boundary goes straight to the
    // shifter. clr_i empties the register and discards a coincident transfer.
    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (clr_i || take_hold) begin
            hold_vld_d = 1'b0;
        end else if (smpl_valid_i && !hold_vld_q && !take_bypass) begin
            hold_vld_d = 1'b1;
            hold_d     = {smpl_l_i, smpl_r_i};
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge aud_clk_i or negedge aud_rst_n_i) begin
        if (!aud_rst_n_i) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            dly_q      <= 1'b0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            udf_q      <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            dly_q      <= dly_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            udf_q      <= udf_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

    assign smpl_ready_o = !hold_vld_q;
    assign sck_o        = sck_w;
    assign ws_o         = ws_q;
    assign sd_o         = sd_q;
    assign busy_o       = (state_q == RUN);
    assign udf_o        = udf_q;

endmodule

// File: tb/tb_i2s_tx_ser.sv
// Bench for i2s_tx_ser: captures ws/sd on every sck rising edge and compares
// them with frames predicted from the accepted sample sequence.
module tb_i2s_tx_ser;

    localparam int DW = 16;
    localparam int PW = 16;
    localparam int FB = 2 * DW;

    logic          aud_clk_i = 1'b0;
    logic          aud_rst_n_i;
    logic          en_i;
    logic          clr_i;
    logic [PW-1:0] pscr_i;
    logic          smpl_valid_i;
    logic          smpl_ready_o;
    logic [DW-1:0] smpl_l_i;
    logic [DW-1:0] smpl_r_i;
    logic          sck_o;
    logic          ws_o;
    logic          sd_o;
    logic          busy_o;
    logic          udf_o;

    int            n_checks;
    int            n_errors;
    int            cyc;
    logic          cap_ws[$];
    logic          cap_sd[$];
    int            cap_cyc[$];
    logic [FB-1:0] exp_q[$];
    logic          sck_prev, udf_prev, rdy_prev;
    int            udf_pulses, udf_cycles, rdy_rises, rdy_cycles;
    bit            feed_on, fix_on, xfer_pend;
    logic [FB-1:0] fix_word;
    logic [FB-1:0] w;
    int            p;

    // Clock
    always #5 aud_clk_i = ~aud_clk_i;

    i2s_tx_ser #(
        .DATA_WIDTH (DW),
        .PSCR_WIDTH (PW)
    ) dut (
        .aud_clk_i    (aud_clk_i),
        .aud_rst_n_i  (aud_rst_n_i),
        .en_i         (en_i),
        .clr_i        (clr_i),
        .pscr_i       (pscr_i),
        .smpl_valid_i (smpl_valid_i),
        .smpl_ready_o (smpl_ready_o),
        .smpl_l_i     (smpl_l_i),
        .smpl_r_i     (smpl_r_i),
        .sck_o        (sck_o),
        .ws_o         (ws_o),
        .sd_o         (sd_o),
        .busy_o       (busy_o),
        .udf_o        (udf_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe outputs on the falling edge, then run the feeder.
    task automatic step();
        @(negedge aud_clk_i);
        cyc++;
        if (sck_o && !sck_prev) begin
            cap_ws.push_back(ws_o);
            cap_sd.push_back(sd_o);
            cap_cyc.push_back(cyc);
        end
        sck_prev = sck_o;
        if (udf_o) udf_cycles++;
        if (udf_o && !udf_prev) udf_pulses++;
        udf_prev = udf_o;
        if (smpl_ready_o) rdy_cycles++;
        if (smpl_ready_o && !rdy_prev) rdy_rises++;
        rdy_prev = smpl_ready_o;
        if (xfer_pend) begin
            xfer_pend = 1'b0;
            if (fix_on) {smpl_l_i, smpl_r_i} = fix_word;
            else        {smpl_l_i, smpl_r_i} = {16'($urandom), 16'($urandom)};
        end
        if (feed_on) begin
            smpl_valid_i = 1'b1;
            if (smpl_ready_o) begin
                exp_q.push_back({smpl_l_i, smpl_r_i});
                xfer_pend = 1'b1;
            end
        end
    endtask

    task automatic clear_stats();
        cap_ws.delete();
        cap_sd.delete();
        cap_cyc.delete();
        sck_prev   = sck_o;
        udf_prev   = udf_o;
        rdy_prev   = smpl_ready_o;
        udf_pulses = 0;
        udf_cycles = 0;
        rdy_rises  = 0;
        rdy_cycles = 0;
    endtask

    task automatic push_word(input logic [FB-1:0] wd);
        {smpl_l_i, smpl_r_i} = wd;
        smpl_valid_i = 1'b1;
        step();
        smpl_valid_i = 1'b0;
    endtask

    task automatic run_bits(input int n);
        int budget;
        budget = 20000;
        while (cap_sd.size() < n && budget > 0) begin
            step();
            budget--;
        end
        if (cap_sd.size() < n) chk("bit_timeout", cap_sd.size(), n);
    endtask

    // Frame f, bit k: ws = right half; sd = word bit (k-1) MSB-first, with
    // bit 0 carrying the previous frame's right LSB (0 for the first frame).
    task automatic check_bits(input int n);
        for (int i = 0; i < n && i < cap_sd.size(); i++) begin
            int            f, k;
            logic          e_ws, e_sd;
            logic [FB-1:0] cur, prv;
            f    = i / FB;
            k    = i % FB;
            e_ws = (k >= DW);
            cur  = exp_q[f];
            if (k == 0) begin
                if (f == 0) e_sd = 1'b0;
                else begin
                    prv  = exp_q[f-1];
                    e_sd = prv[0];
                end
            end else begin
                e_sd = cur[FB-k];
            end
            chk($sformatf("ws f%0d b%0d", f, k), cap_ws[i], e_ws);
            chk($sformatf("sd f%0d b%0d", f, k), cap_sd[i], e_sd);
        end
    endtask

    task automatic check_period(input int ps);
        for (int i = 1; i < cap_cyc.size(); i++)
            chk($sformatf("sck period b%0d", i), cap_cyc[i] - cap_cyc[i-1], 2 * (ps + 1));
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        aud_rst_n_i = 1'b0; en_i = 1'b0; clr_i = 1'b0; pscr_i = '0;
        smpl_valid_i = 1'b0; smpl_l_i = '0; smpl_r_i = '0;
        feed_on = 1'b0; fix_on = 1'b0; xfer_pend = 1'b0; fix_word = '0;
        sck_prev = 1'b0; udf_prev = 1'b0; rdy_prev = 1'b0;
        repeat (3) @(negedge aud_clk_i);

        // Reset values
        chk("rst sck", sck_o, 0);
        chk("rst ws", ws_o, 0);
        chk("rst sd", sd_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst udf", udf_o, 0);
        chk("rst ready", smpl_ready_o, 1);
        aud_rst_n_i = 1'b1;
        step(); step();

        // Preloaded A5A5/3C3C at pscr=1, then underflow in frame 2
        pscr_i = 1;
        push_word(32'hA5A5_3C3C);
        chk("t1 ready full", smpl_ready_o, 0);
        exp_q.delete();
        exp_q.push_back(32'hA5A5_3C3C);
        exp_q.push_back(32'h0);
        clear_stats();
        en_i = 1'b1;
        run_bits(64);
        chk("t1 busy", busy_o, 1);
        check_bits(64);
        check_period(1);
        chk("t1 udf pulses", udf_pulses, 1);
        chk("t1 udf cycles", udf_cycles, 1);
        en_i = 1'b0;
        step(); step();

        // pscr=0 with continuous valid, constant FFFF/0000
        pscr_i = 0;
        fix_on = 1'b1; fix_word = 32'hFFFF_0000;
        {smpl_l_i, smpl_r_i} = fix_word;
        exp_q.delete();
        feed_on = 1'b1;
        step(); step();
        clear_stats();
        en_i = 1'b1;
        run_bits(128);
        check_bits(128);
        check_period(0);
        chk("t2 udf", udf_pulses, 0);
        chk("t2 ready rises", rdy_rises, 4);
        chk("t2 ready cycles", rdy_cycles, 4);
        feed_on = 1'b0; smpl_valid_i = 1'b0; en_i = 1'b0; fix_on = 1'b0;
        clr_i = 1'b1; step(); clr_i = 1'b0; step();

        // Random data and prescaler with continuous valid
        for (int it = 0; it < 3; it++) begin
            p = $urandom_range(0, 3);
            pscr_i = PW'(p);
            xfer_pend = 1'b0;
            {smpl_l_i, smpl_r_i} = {16'($urandom), 16'($urandom)};
            exp_q.delete();
            feed_on = 1'b1;
            repeat (3) step();
            clear_stats();
            en_i = 1'b1;
            run_bits(96);
            check_bits(96);
            check_period(p);
            chk($sformatf("rand%0d udf", it), udf_pulses, 0);
            feed_on = 1'b0; smpl_valid_i = 1'b0; en_i = 1'b0;
            clr_i = 1'b1; step(); clr_i = 1'b0; step();
        end

        // Bypass: sample offered exactly on the first boundary, register empty
        pscr_i = 1;
        chk("byp ready pre", smpl_ready_o, 1);
        w = {16'($urandom), 16'($urandom)};
        exp_q.delete();
        exp_q.push_back(w);
        exp_q.push_back(32'h0);
        clear_stats();
        en_i = 1'b1;
        step();
        {smpl_l_i, smpl_r_i} = w;
        smpl_valid_i = 1'b1;
        step();
        smpl_valid_i = 1'b0;
        chk("byp ready post", smpl_ready_o, 1);
        run_bits(64);
        check_bits(64);
        chk("byp udf pulses", udf_pulses, 1);
        en_i = 1'b0;
        step(); step();

        // en_i dropped during bit 9, then restart from bit 0
        w = {16'h00FF, 16'($urandom)};
        push_word(w);
        exp_q.delete();
        exp_q.push_back(w);
        clear_stats();
        en_i = 1'b1;
        run_bits(10);
        check_bits(10);
        chk("drop sck pre", sck_o, 1);
        en_i = 1'b0;
        step();
        chk("drop sck", sck_o, 0);
        chk("drop ws", ws_o, 0);
        chk("drop sd", sd_o, 0);
        chk("drop busy", busy_o, 0);
        w = {16'($urandom), 16'($urandom)};
        push_word(w);
        exp_q.delete();
        exp_q.push_back(w);
        clear_stats();
        en_i = 1'b1;
        run_bits(32);
        check_bits(32);
        en_i = 1'b0;
        step(); step();

        // clr_i flushes a preload and wins over a coincident push
        pscr_i = 0;
        push_word({16'($urandom), 16'($urandom)});
        chk("clr ready full", smpl_ready_o, 0);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("clr ready", smpl_ready_o, 1);
        {smpl_l_i, smpl_r_i} = {16'($urandom), 16'($urandom)};
        smpl_valid_i = 1'b1; clr_i = 1'b1;
        step();
        smpl_valid_i = 1'b0; clr_i = 1'b0;
        chk("clr push dropped", smpl_ready_o, 1);
        exp_q.delete();
        exp_q.push_back(32'h0);
        clear_stats();
        en_i = 1'b1;
        run_bits(32);
        check_bits(32);
        chk("clr udf pulses", udf_pulses, 1);
        chk("clr udf cycles", udf_cycles, 1);
        en_i = 1'b0;
        step(); step();

        // Asynchronous reset mid-frame
        pscr_i = 1;
        push_word(32'hFFFF_FFFF);
        clear_stats();
        en_i = 1'b1;
        run_bits(5);
        chk("arst busy pre", busy_o, 1);
        #2;
        aud_rst_n_i = 1'b0;
        #1;
        chk("arst sck", sck_o, 0);
        chk("arst ws", ws_o, 0);
        chk("arst sd", sd_o, 0);
        chk("arst busy", busy_o, 0);
        chk("arst udf", udf_o, 0);
        chk("arst ready", smpl_ready_o, 1);
        en_i = 1'b0;
        step();
        aud_rst_n_i = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
